// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, memory
// access direction constants and the default memory window.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] DEFAULT_STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] DEFAULT_MEM_DEPTH_BYTES = 32'h0010_0000;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-pc select (redirect target or pc+4) and legality check
// against the word-aligned fetch window.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = DEFAULT_STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = DEFAULT_MEM_DEPTH_BYTES
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic        next_legal
);

  logic [32:0] seq_sum;
  logic [32:0] candidate;
  logic [32:0] last_legal;

  // 33-bit arithmetic so pc+4 past 2^32 is seen as out of range, not wrapped.
  always_comb begin
    seq_sum    = {1'b0, pc} + 33'd4;
    last_legal = {1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES} - 33'd4;
    candidate  = redirect_valid ? {1'b0, redirect_pc} : seq_sum;
    next_pc    = candidate[31:0];
    next_legal = (candidate[1:0] == 2'b00) &&
                 (candidate >= {1'b0, STARTING_ADDR}) &&
                 (candidate <= last_legal);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives pc to memory, registers the returned word
// with its address, and hands it to decode over a valid/ready channel.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = DEFAULT_STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = DEFAULT_MEM_DEPTH_BYTES
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         run,
  output logic [31:0]  mem_address,
  output logic         mem_read_write,
  input  logic [31:0]  mem_data_out,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         fault,
  output logic [31:0]  fault_pc,
  output logic [31:0]  fetch_count,
  output fetch_state_e state
);

  // Decode channel: a transfer happens on a rising edge where inst_valid and
  // inst_ready are both 1; while inst_valid=1 and inst_ready=0, inst/inst_pc
  // hold steady. inst_valid never depends combinationally on inst_ready.

  fetch_state_e state_next;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         next_legal;
  logic         handshake;
  logic         last_pending;
  logic         capture;
  logic         take_redirect;
  logic         take_fault;

  fetch_pc_next #(
    .STARTING_ADDR  (STARTING_ADDR),
    .MEM_DEPTH_BYTES(MEM_DEPTH_BYTES)
  ) u_pc_next (
    .pc            (pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .next_pc       (next_pc),
    .next_legal    (next_legal)
  );

  assign mem_address    = pc;
  assign mem_read_write = READ;
  assign handshake      = inst_valid & inst_ready;
  // pc is left on the last legal word after delivering it, so a valid
  // instruction from the current pc means pc+4 overflowed the window.
  assign last_pending   = inst_valid && (inst_pc == pc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    capture       = 1'b0;
    take_redirect = 1'b0;
    take_fault    = 1'b0;
    if (state != ST_FAULT) begin
      if (redirect_valid) begin
        if (next_legal) begin
          take_redirect = 1'b1;
          if (state != ST_IDLE) state_next = ST_RUN;
        end else begin
          take_fault = 1'b1;
          state_next = ST_FAULT;
        end
      end else if (state == ST_IDLE) begin
        if (run) state_next = ST_RUN;
      end else if (inst_valid && !inst_ready) begin
        state_next = ST_HOLD;
      end else if (last_pending) begin
        take_fault = 1'b1;
        state_next = ST_FAULT;
      end else begin
        capture    = 1'b1;
        state_next = ST_RUN;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= STARTING_ADDR;
      inst_valid  <= 1'b0;
      inst        <= 32'd0;
      inst_pc     <= 32'd0;
      fault       <= 1'b0;
      fault_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      if (handshake) fetch_count <= fetch_count + 32'd1;
      if (take_fault) begin
        fault      <= 1'b1;
        fault_pc   <= next_pc;
        inst_valid <= 1'b0;
      end else if (take_redirect) begin
        pc         <= next_pc;
        inst_valid <= 1'b0;
      end else if (capture) begin
        inst       <= mem_data_out;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
        if (next_legal) pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] START = DEFAULT_STARTING_ADDR;
  localparam logic [31:0] DEPTH = DEFAULT_MEM_DEPTH_BYTES;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         run = 1'b0;
  logic [31:0]  mem_address;
  logic         mem_read_write;
  logic [31:0]  mem_data_out;
  logic         inst_valid;
  logic         inst_ready = 1'b0;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'd0;
  logic         fault;
  logic [31:0]  fault_pc;
  logic [31:0]  fetch_count;
  fetch_state_e state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  instruction_fetch #(
    .STARTING_ADDR  (START),
    .MEM_DEPTH_BYTES(DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .run           (run),
    .mem_address   (mem_address),
    .mem_read_write(mem_read_write),
    .mem_data_out  (mem_data_out),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count),
    .state         (state)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == START)          return 32'h0000_0093;
    if (a == START + 32'd4)  return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_data_out = mem_word(mem_address);

  function automatic bit legal(input longint a);
    return (a % 4 == 0) && (a >= longint'(START)) &&
           (a + 4 <= longint'(START) + longint'(DEPTH));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state of the fetch stage.
  fetch_state_e m_state;
  logic [31:0]  m_pc, m_inst, m_ipc, m_fpc, m_cnt;
  logic         m_valid, m_fault, m_last;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= ST_IDLE; m_pc <= START; m_valid <= 1'b0; m_inst <= 32'd0;
      m_ipc <= 32'd0; m_fault <= 1'b0; m_fpc <= 32'd0; m_cnt <= 32'd0; m_last <= 1'b0;
    end else if (m_state != ST_FAULT) begin
      if (m_valid && inst_ready) m_cnt <= m_cnt + 32'd1;
      if (redirect_valid) begin
        if (legal(longint'(redirect_pc))) begin
          m_pc <= redirect_pc; m_valid <= 1'b0; m_last <= 1'b0;
          if (m_state != ST_IDLE) m_state <= ST_RUN;
        end else begin
          m_state <= ST_FAULT; m_fault <= 1'b1; m_fpc <= redirect_pc; m_valid <= 1'b0;
        end
      end else if (m_state == ST_IDLE) begin
        if (run) m_state <= ST_RUN;
      end else if (m_valid && !inst_ready) begin
        m_state <= ST_HOLD;
      end else if (m_last) begin
        m_state <= ST_FAULT; m_fault <= 1'b1; m_fpc <= m_pc + 32'd4; m_valid <= 1'b0;
      end else begin
        m_inst <= mem_word(m_pc); m_ipc <= m_pc; m_valid <= 1'b1; m_state <= ST_RUN;
        if (legal(longint'(m_pc) + 4)) m_pc <= m_pc + 32'd4;
        else m_last <= 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("state", 32'(state), 32'(m_state));
      chk("mem_address", mem_address, m_pc);
      chk("mem_read_write", 32'(mem_read_write), 32'(READ));
      chk("inst_valid", 32'(inst_valid), 32'(m_valid));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fault_pc", fault_pc, m_fpc);
      chk("fetch_count", fetch_count, m_cnt);
      if (m_valid) begin
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #2 reset_n = 1'b0;
    run = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [31:0] target;
  int r, k;

  initial begin
    do_reset();
    cmp_en = 1'b1;

    // Two-word sequential fetch with decode always ready.
    run = 1'b1; inst_ready = 1'b1;
    @(negedge clock); chk("idle_to_run_no_capture", 32'(inst_valid), 32'd0);
    @(negedge clock);
    chk("first_inst", inst, 32'h0000_0093);
    chk("first_pc", inst_pc, 32'h0100_0000);
    chk("first_count", fetch_count, 32'd0);
    @(negedge clock);
    chk("second_inst", inst, 32'h0010_0113);
    chk("second_pc", inst_pc, 32'h0100_0004);
    chk("second_count", fetch_count, 32'd1);
    @(negedge clock);
    chk("third_pc", inst_pc, 32'h0100_0008);
    inst_ready = 1'b0;

    // Decode stalls for three cycles.
    repeat (3) begin
      @(negedge clock);
      chk("hold_inst", inst, mem_word(32'h0100_0008));
      chk("hold_pc", inst_pc, 32'h0100_0008);
      chk("hold_mem_address", mem_address, 32'h0100_000C);
      chk("hold_count", fetch_count, 32'd2);
    end
    inst_ready = 1'b1;
    @(negedge clock);
    chk("release_pc", inst_pc, 32'h0100_000C);
    chk("release_count", fetch_count, 32'd3);

    // Redirect flush.
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0040;
    @(negedge clock);
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_count", fetch_count, 32'd4);
    @(negedge clock);
    chk("redirect_pc", inst_pc, 32'h0100_0040);

    // Last legal word, then sequential overflow fault.
    redirect_valid = 1'b1; redirect_pc = 32'h010F_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("last_word_pc", inst_pc, 32'h010F_FFFC);
    chk("last_word_valid", 32'(inst_valid), 32'd1);
    chk("last_word_no_fault", 32'(fault), 32'd0);
    @(negedge clock);
    chk("overflow_fault", 32'(fault), 32'd1);
    chk("overflow_fault_pc", fault_pc, 32'h0110_0000);
    chk("overflow_mem_address", mem_address, 32'h010F_FFFC);

    // Misaligned redirect; FAULT ignores later inputs.
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    @(negedge clock);
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0042;
    @(negedge clock);
    chk("misalign_fault", 32'(fault), 32'd1);
    chk("misalign_fault_pc", fault_pc, 32'h0100_0042);
    chk("misalign_valid", 32'(inst_valid), 32'd0);
    redirect_pc = 32'h0100_0040;
    repeat (3) @(negedge clock);
    redirect_valid = 1'b0;
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_pc_sticky", fault_pc, 32'h0100_0042);
    chk("fault_mem_address", mem_address, 32'h0100_0000);

    // Asynchronous reset during HOLD.
    do_reset();
    run = 1'b1; inst_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("in_hold", 32'(state), 32'(ST_HOLD));
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'd0);
    chk("arst_count", fetch_count, 32'd0);
    chk("arst_mem_address", mem_address, START);
    chk("arst_state", 32'(state), 32'(ST_IDLE));
    @(negedge clock);
    reset_n = 1'b1; run = 1'b1; inst_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("resume_pc", inst_pc, 32'h0100_0000);
    chk("resume_inst", inst, 32'h0000_0093);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 12; seg++) begin
      do_reset();
      repeat (200) begin
        @(negedge clock);
        run        = ($urandom_range(0, 3) != 0);
        inst_ready = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 199);
        k = $urandom_range(0, 9);
        if (r < 10) begin
          if (k < 4) target = START + DEPTH - 32'(4 * $urandom_range(1, 4));
          else       target = START + (32'($urandom_range(0, 32'h3FFFF)) << 2);
        end else if (r == 10) begin
          if (k < 4)      target = START + 32'($urandom_range(1, 3));
          else if (k < 7) target = START - 32'd4;
          else            target = START + DEPTH;
        end else begin
          target = 32'd0;
        end
        redirect_valid = (r <= 10);
        redirect_pc    = target;
      end
    end
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
